// File: rtl/fp_mult_arb_pkg.sv
// Shared constants and helpers for the multiplier arbiter and its tag FIFO.
// Holds the float width, the ID-width function and IEEE-754 single-precision constants.
package fp_mult_arb_pkg;

    localparam int FP_WIDTH = 32;

    localparam logic [FP_WIDTH-1:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [FP_WIDTH-1:0] FP_TWO   = 32'h4000_0000;
    localparam logic [FP_WIDTH-1:0] FP_THREE = 32'h4040_0000;
    localparam logic [FP_WIDTH-1:0] FP_SIX   = 32'h40C0_0000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_mult_tag_fifo.sv
// In-order tag FIFO recording which requester issued each in-flight multiply.
// Head is combinational; push when full and pop when empty are ignored; push and pop may share a cycle.
module fp_mult_tag_fifo
    import fp_mult_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                     clkIn,
    input  logic                     rstIn,
    input  logic                     pushIn,
    input  logic [WIDTH-1:0]         pushDataIn,
    input  logic                     popIn,
    output logic [WIDTH-1:0]         popDataOut,
    output logic [clog2(DEPTH):0]    countOut
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;

    assign pop_en  = popIn && (count_q != '0);
    assign push_en = pushIn && (count_q != CNT_W'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge clkIn) begin
        if (push_en) mem_q[wr_ptr_q] <= pushDataIn;
    end

    assign popDataOut = mem_q[rd_ptr_q];
    assign countOut   = count_q;

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin share of one pipelined FP multiplier; 1 cycle issue + multiplier latency + 1 cycle return.
// Ready drops with MAX_OUTSTANDING in flight; no response backpressure. FP_MULT_ARB_ERR_EN adds sticky errorOut.
module fp_mult_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                        clkIn,
    input  logic                        rstIn,
    input  logic [NUM_REQ-1:0]          reqValidIn,
    input  logic [NUM_REQ*FP_WIDTH-1:0] reqDataAIn,
    input  logic [NUM_REQ*FP_WIDTH-1:0] reqDataBIn,
    output logic [NUM_REQ-1:0]          reqReadyOut,
    output logic [FP_WIDTH-1:0]         mulDataAOut,
    output logic [FP_WIDTH-1:0]         mulDataBOut,
    output logic                        mulValidOut,
    input  logic [FP_WIDTH-1:0]         mulDataIn,
    input  logic                        mulValidIn,
    output logic [NUM_REQ-1:0]          rspValidOut,
    output logic [FP_WIDTH-1:0]         rspDataOut
`ifdef FP_MULT_ARB_ERR_EN
    ,
    output logic                        errorOut
`endif
);

    localparam int ID_W  = clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_OUTSTANDING) + 1;

    logic [ID_W-1:0]     last_grant_q;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic                credit_ok;
    logic                xfer;
    logic                pop_en;
    logic [ID_W-1:0]     tag_head;
    logic [CNT_W-1:0]    tag_count;
    logic [FP_WIDTH-1:0] mul_a_q, mul_b_q, rsp_dat_q;
    logic                mul_vld_q;
    logic [NUM_REQ-1:0]  rsp_vld_q;
    int                  cand;

    // Search begins just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = last_grant_q;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && reqValidIn[cand]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(cand);
            end
        end
    end

    // Count is registered, so a same-cycle pop only frees its credit next cycle.
    assign credit_ok   = tag_count < CNT_W'(MAX_OUTSTANDING);
    assign xfer        = rstIn && grant_found && credit_ok;
    assign reqReadyOut = xfer ? (NUM_REQ'(1) << grant_id) : '0;
    assign pop_en      = mulValidIn && (tag_count != '0);

    fp_mult_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .pushIn     (xfer),
        .pushDataIn (grant_id),
        .popIn      (pop_en),
        .popDataOut (tag_head),
        .countOut   (tag_count)
    );

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            mul_vld_q    <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_vld_q    <= '0;
            rsp_dat_q    <= '0;
        end else begin
            mul_vld_q <= xfer;
            if (xfer) begin
                last_grant_q <= grant_id;
                mul_a_q      <= reqDataAIn[grant_id*FP_WIDTH +: FP_WIDTH];
                mul_b_q      <= reqDataBIn[grant_id*FP_WIDTH +: FP_WIDTH];
            end
            rsp_vld_q <= pop_en ? (NUM_REQ'(1) << tag_head) : '0;
            if (pop_en) rsp_dat_q <= mulDataIn;
        end
    end

    assign mulValidOut = mul_vld_q;
    assign mulDataAOut = mul_a_q;
    assign mulDataBOut = mul_b_q;
    assign rspValidOut = rsp_vld_q;
    assign rspDataOut  = rsp_dat_q;

`ifdef FP_MULT_ARB_ERR_EN
    logic err_q;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) err_q <= 1'b0;
        else        err_q <= err_q | (mulValidIn && (tag_count == '0));
    end

    assign errorOut = err_q;
`endif

endmodule
